// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the tagged APB2AXI gateway.
package apb2axi_pkg;

    localparam int unsigned TAG_W        = 3;
    localparam int unsigned ENTRY_ADDR_W = 64;

    // Word offsets, i.e. PADDR[4:2]
    localparam logic [2:0] REG_ADDR_LO = 3'd0;
    localparam logic [2:0] REG_ADDR_HI = 3'd1;
    localparam logic [2:0] REG_CMD     = 3'd2;
    localparam logic [2:0] REG_COMMIT  = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    localparam int unsigned STATUS_ERR_BIT = 17;

    typedef enum logic [1:0] {
        FREE    = 2'd0,
        PENDING = 2'd1,
        ISSUED  = 2'd2
    } tag_state_e;

    typedef struct packed {
        logic                    is_write;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic [TAG_W-1:0]        tag;
    } directory_entry_t;

endpackage

// File: rtl/apb2axi_gateway_tagged_if.sv
// APB slave, dispatch and completion signals of the tagged gateway.
interface apb2axi_gateway_tagged_if #(
    parameter int unsigned APB_ADDR_W = 16,
    parameter int unsigned APB_DATA_W = 32
);
    import apb2axi_pkg::*;

    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_ADDR_W-1:0] PADDR;
    logic [APB_DATA_W-1:0] PWDATA;
    logic [APB_DATA_W-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    logic                  disp_valid;
    logic                  disp_ready;
    directory_entry_t      disp_entry;

    logic                  cpl_valid;
    logic [TAG_W-1:0]      cpl_tag;

    logic                  irq_err;

    // Gateway side
    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR,
        output disp_valid, disp_entry,
        input  disp_ready,
        input  cpl_valid, cpl_tag,
        output irq_err
    );

    // APB master / AXI builder side
    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR,
        input  disp_valid, disp_entry,
        output disp_ready,
        output cpl_valid, cpl_tag,
        input  irq_err
    );

endinterface

// File: rtl/apb2axi_tag_fifo.sv
// In-order tag FIFO; pointers carry a wrap bit so any depth works.
// Occupancy is bounded by the directory, so no full output is needed.
module apb2axi_tag_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             wr_wrap, rd_wrap;

    function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
        return (idx == LAST) ? '0 : idx + 1'b1;
    endfunction

    // Pointer advance with wrap toggle on rollover
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_idx  <= '0;
            rd_wrap <= 1'b0;
        end else begin
            if (push) begin
                wr_idx <= next_idx(wr_idx);
                if (wr_idx == LAST) wr_wrap <= ~wr_wrap;
            end
            if (pop) begin
                rd_idx <= next_idx(rd_idx);
                if (rd_idx == LAST) rd_wrap <= ~rd_wrap;
            end
        end
    end

    // Storage needs no reset; empty flag masks stale contents
    always_ff @(posedge clk) begin
        if (push) mem[wr_idx] <= push_data;
    end

    assign head  = mem[rd_idx];
    assign empty = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);

endmodule

// File: rtl/apb2axi_gateway_tagged.sv
// APB register front end: stages descriptors, allocates tags, dispatches in order.
module apb2axi_gateway_tagged
    import apb2axi_pkg::*;
#(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned APB_ADDR_W = 16,
    parameter int unsigned APB_DATA_W = 32,
    parameter int unsigned NUM_TAGS   = 8
) (
    input logic                     PCLK,
    input logic                     PRESETn,
    apb2axi_gateway_tagged_if.slave bus
);
    localparam int unsigned CNT_W = TAG_W + 1;
    localparam logic [63:0] ADDR_MASK =
        (AXI_ADDR_W >= 64) ? {64{1'b1}} : ((64'd1 << AXI_ADDR_W) - 64'd1);

    logic [63:0]      addr_q;
    logic [7:0]       len_q;
    logic [2:0]       size_q;
    logic             is_write_q;
    logic [1:0]       burst_q;
    logic [CNT_W-1:0] free_cnt_q, free_cnt_d;
    logic [TAG_W-1:0] last_tag_q;
    logic             err_q, err_d;

    tag_state_e       state_q [NUM_TAGS];
    directory_entry_t dir_q   [NUM_TAGS];

    logic             access, full, commit_req, commit, slverr;
    logic [2:0]       offset;
    logic [TAG_W-1:0] alloc_tag, head_tag;
    logic             fifo_empty, pop, cpl_in_range, cpl_ok, cpl_bad, w1c_err;
    logic [APB_DATA_W-1:0] rdata;
    logic             unused_bits;

    assign access     = bus.PSEL & bus.PENABLE;
    assign offset     = bus.PADDR[4:2];
    assign full       = (free_cnt_q == '0);
    assign commit_req = access & bus.PWRITE & (offset == REG_COMMIT);
    assign commit     = commit_req & ~full;
    assign slverr     = access & ((offset > REG_STATUS) |
                                  (~bus.PWRITE & (offset == REG_COMMIT)) |
                                  (commit_req & full));
    assign w1c_err    = access & bus.PWRITE & (offset == REG_STATUS) &
                        bus.PWDATA[STATUS_ERR_BIT];

    assign pop          = ~fifo_empty & bus.disp_ready;
    assign cpl_in_range = 32'(bus.cpl_tag) < NUM_TAGS;
    assign cpl_ok       = bus.cpl_valid & cpl_in_range & (state_q[bus.cpl_tag] == ISSUED);
    assign cpl_bad      = bus.cpl_valid & ~cpl_ok;

    assign unused_bits = ^{bus.PADDR[APB_ADDR_W-1:5], bus.PADDR[1:0], bus.PWDATA};

    // Lowest-index FREE tag wins; only used when free_cnt is non-zero
    always_comb begin
        alloc_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) alloc_tag = TAG_W'(i);
        end
    end

    // Commit and completion in the same cycle cancel out
    always_comb begin
        free_cnt_d = free_cnt_q - CNT_W'(commit) + CNT_W'(cpl_ok);
        err_d      = err_q;
        if (w1c_err) err_d = 1'b0;
        if ((commit_req & full) | cpl_bad) err_d = 1'b1;
    end

    // Read mux; PRDATA is only driven during a read access
    always_comb begin
        rdata = '0;
        if (access && !bus.PWRITE) begin
            case (offset)
                REG_ADDR_LO: rdata = APB_DATA_W'(addr_q[31:0]);
                REG_ADDR_HI: rdata = APB_DATA_W'(addr_q[63:32]);
                REG_CMD:     rdata = APB_DATA_W'({burst_q, is_write_q, size_q, len_q});
                REG_STATUS:  rdata = APB_DATA_W'({err_q, full, 8'(last_tag_q), 8'(free_cnt_q)});
                default:     rdata = '0;
            endcase
        end
    end

    // Staging registers, counters and sticky error
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            addr_q     <= '0;
            len_q      <= '0;
            size_q     <= '0;
            is_write_q <= 1'b0;
            burst_q    <= '0;
            free_cnt_q <= CNT_W'(NUM_TAGS);
            last_tag_q <= '0;
            err_q      <= 1'b0;
        end else begin
            if (access && bus.PWRITE) begin
                case (offset)
                    REG_ADDR_LO: addr_q[31:0]  <= bus.PWDATA[31:0] & ADDR_MASK[31:0];
                    REG_ADDR_HI: addr_q[63:32] <= bus.PWDATA[31:0] & ADDR_MASK[63:32];
                    REG_CMD: begin
                        len_q      <= bus.PWDATA[7:0];
                        size_q     <= bus.PWDATA[10:8];
                        is_write_q <= bus.PWDATA[11];
                        burst_q    <= bus.PWDATA[13:12];
                    end
                    default: ;
                endcase
            end
            if (commit) last_tag_q <= alloc_tag;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    // Tag lifecycle; commit, pop and completion always touch distinct tags
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NUM_TAGS; i++) state_q[i] <= FREE;
        end else begin
            if (commit) state_q[alloc_tag] <= PENDING;
            if (pop)    state_q[head_tag]  <= ISSUED;
            if (cpl_ok) state_q[bus.cpl_tag] <= FREE;
        end
    end

    // Descriptor capture; validity is tracked by state_q
    always_ff @(posedge PCLK) begin
        if (commit) begin
            dir_q[alloc_tag] <= '{is_write: is_write_q, addr: addr_q, len: len_q,
                                  size: size_q, burst: burst_q, tag: alloc_tag};
        end
    end

    apb2axi_tag_fifo #(
        .DEPTH (NUM_TAGS),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk       (PCLK),
        .rst_n     (PRESETn),
        .push      (commit),
        .push_data (alloc_tag),
        .pop       (pop),
        .head      (head_tag),
        .empty     (fifo_empty)
    );

    assign bus.disp_valid = ~fifo_empty;
    assign bus.disp_entry = dir_q[head_tag];
    assign bus.PRDATA     = rdata;
    assign bus.PREADY     = 1'b1;
    assign bus.PSLVERR    = slverr;
    assign bus.irq_err    = err_q;

endmodule
